// File: rtl/icb_uart_fifo_pkg.sv
// Shared definitions for the ICB UART: register offsets (addr[4:2]), field
// bit positions, FSM state encoding and the parity helper.
package icb_uart_fifo_pkg;
    localparam logic [2:0] A_TXDATA = 3'd0;
    localparam logic [2:0] A_RXDATA = 3'd1;
    localparam logic [2:0] A_CTRL   = 3'd2;
    localparam logic [2:0] A_DIV    = 3'd3;
    localparam logic [2:0] A_STATUS = 3'd4;
    localparam logic [2:0] A_IE     = 3'd5;

    localparam int C_BAUD_EN  = 0;
    localparam int C_TX_EN    = 1;
    localparam int C_RX_EN    = 2;
    localparam int C_PAR_EN   = 3;
    localparam int C_PAR_EVEN = 4;
    localparam int C_STOP2    = 5;

    // sticky index i lives at STATUS[4+i]
    localparam int S_RXOVF  = 0;
    localparam int S_PARERR = 1;
    localparam int S_FRMERR = 2;
    localparam int S_TXOVF  = 3;

    localparam int IE_TXWM = 0;
    localparam int IE_RXWM = 1;
    localparam int IE_ERR  = 2;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_st_e;

    function automatic logic par_bit(input logic [7:0] d, input logic even);
        return even ? ^d : ~^d;
    endfunction
endpackage

// File: rtl/icb_uart_fifo_sync_fifo.sv
// Synchronous FIFO with count; a push into a full FIFO succeeds when a pop
// of a non-empty FIFO happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        cnt_d    = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/icb_uart_fifo.sv
// ICB-attached UART with TX/RX FIFOs, 16x oversampled receive, sticky error
// flags and a maskable watermark/error interrupt.
module icb_uart_fifo
    import icb_uart_fifo_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter int          FIFO_DEPTH = 8,
    parameter int          DATA_BITS  = 8,
    parameter logic [15:0] DIV_RST    = 16'd53
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_icb_cmd_valid,
    output logic              i_icb_cmd_ready,
    input  logic [ADDR_W-1:0] i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [31:0]       i_icb_cmd_wdata,
    output logic              i_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic [31:0]       i_icb_rsp_rdata,
    output logic              io_irq,
    output logic              io_txd,
    input  logic              io_rxd
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rsp_valid_q, rsp_valid_d, irq_q, irq_d, txd_q, txd_d;
    logic [31:0]      rdata_q, rdata_d, status;
    logic [5:0]       ctrl_q, ctrl_d;
    logic [15:0]      div_q, div_d, tick_cnt_q, tick_cnt_d;
    logic [2:0]       ie_q, ie_d;
    logic [7:0]       tx_wm_q, tx_wm_d, rx_wm_q, rx_wm_d;
    logic [3:0]       sticky_q, sticky_d;
    logic [2:0]       sel, rx_sync_q, rx_sync_d;
    logic             acc, wr, rd, tick, rxd_s, rxd_prev;
    logic             tx_push, tx_pop, tx_full, tx_empty, rx_push, rx_pop, rx_full, rx_empty;
    logic             set_par, set_frm;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;
    logic [DATA_BITS-1:0] tx_dout, rx_dout;

    uart_st_e             tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [3:0]           tx_ph_q, tx_ph_d, rx_ph_q, rx_ph_d;
    logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic                 tx_par_q, tx_par_d, tx_stop_q, tx_stop_d;

    logic unused_bits;
    assign unused_bits = ^{i_icb_cmd_addr[ADDR_W-1:5], i_icb_cmd_addr[1:0], i_icb_cmd_wdata[31:24]};

    assign sel      = i_icb_cmd_addr[4:2];
    assign acc      = i_icb_cmd_valid & ~rsp_valid_q;
    assign wr       = acc & ~i_icb_cmd_read;
    assign rd       = acc & i_icb_cmd_read;
    assign tx_push  = wr & (sel == A_TXDATA);
    assign rx_pop   = rd & (sel == A_RXDATA);
    assign rxd_s    = rx_sync_q[1];
    assign rxd_prev = rx_sync_q[2];
    assign tick     = ctrl_q[C_BAUD_EN] & (tick_cnt_q == div_q);

    assign i_icb_cmd_ready = ~rsp_valid_q;
    assign i_icb_rsp_valid = rsp_valid_q;
    assign i_icb_rsp_rdata = rdata_q;
    assign io_irq          = irq_q;
    assign io_txd          = txd_q;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .wdata(i_icb_cmd_wdata[DATA_BITS-1:0]),
        .pop(tx_pop), .rdata(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_cnt));

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .wdata(rx_sh_q),
        .pop(rx_pop), .rdata(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt));

    always_comb begin
        status                 = '0;
        status[3:0]            = {rx_full, rx_empty, tx_full, tx_empty};
        status[7:4]            = sticky_q;
        status[CNT_W+7:8]      = tx_cnt;
        status[CNT_W+15:16]    = rx_cnt;
    end

    // Register file and ICB response
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        ctrl_d      = ctrl_q;
        div_d       = div_q;
        ie_d        = ie_q;
        tx_wm_d     = tx_wm_q;
        rx_wm_d     = rx_wm_q;
        if (acc) rsp_valid_d = 1'b1;
        else if (i_icb_rsp_ready) rsp_valid_d = 1'b0;
        if (acc) rdata_d = '0;
        if (rd) begin
            case (sel)
                A_RXDATA: rdata_d = rx_empty ? 32'h8000_0000 : {24'b0, 8'(rx_dout)};
                A_CTRL:   rdata_d = {26'b0, ctrl_q};
                A_DIV:    rdata_d = {16'b0, div_q};
                A_STATUS: rdata_d = status;
                A_IE:     rdata_d = {8'b0, rx_wm_q, tx_wm_q, 5'b0, ie_q};
                default:  rdata_d = '0;
            endcase
        end
        if (wr) begin
            case (sel)
                A_CTRL:  ctrl_d = i_icb_cmd_wdata[5:0];
                A_DIV:   div_d  = i_icb_cmd_wdata[15:0];
                A_IE: begin
                    ie_d    = i_icb_cmd_wdata[2:0];
                    tx_wm_d = i_icb_cmd_wdata[15:8];
                    rx_wm_d = i_icb_cmd_wdata[23:16];
                end
                default: ;
            endcase
        end
        // W1C first, so a set event in the same cycle wins
        sticky_d = sticky_q & ~((wr && sel == A_STATUS) ? i_icb_cmd_wdata[7:4] : 4'b0);
        sticky_d[S_TXOVF]  = sticky_d[S_TXOVF]  | (tx_push & tx_full & ~(tx_pop & ~tx_empty));
        sticky_d[S_RXOVF]  = sticky_d[S_RXOVF]  | (rx_push & rx_full & ~(rx_pop & ~rx_empty));
        sticky_d[S_PARERR] = sticky_d[S_PARERR] | set_par;
        sticky_d[S_FRMERR] = sticky_d[S_FRMERR] | set_frm;
        irq_d = (ie_q[IE_TXWM] & (8'(tx_cnt) <= tx_wm_q))
              | (ie_q[IE_RXWM] & (8'(rx_cnt) >= rx_wm_q) & (rx_cnt != '0))
              | (ie_q[IE_ERR]  & (|sticky_q));
        tick_cnt_d = (!ctrl_q[C_BAUD_EN] || (wr && sel == A_DIV) || tick) ? 16'd0 : tick_cnt_q + 16'd1;
        rx_sync_d  = {rx_sync_q[1:0], io_rxd};
    end

    // TX FSM
    always_comb begin
        tx_st_d   = tx_st_q;
        tx_ph_d   = tx_ph_q;
        tx_bit_d  = tx_bit_q;
        tx_sh_d   = tx_sh_q;
        tx_par_d  = tx_par_q;
        tx_stop_d = tx_stop_q;
        tx_pop    = 1'b0;
        if (!ctrl_q[C_BAUD_EN]) begin
            tx_st_d = ST_IDLE;
            tx_ph_d = '0;
        end else if (tx_st_q == ST_IDLE) begin
            if (ctrl_q[C_TX_EN] && !tx_empty) begin
                tx_pop    = 1'b1;
                tx_sh_d   = tx_dout;
                tx_par_d  = par_bit(8'(tx_dout), ctrl_q[C_PAR_EVEN]);
                tx_st_d   = ST_START;
                tx_ph_d   = '0;
                tx_bit_d  = '0;
                tx_stop_d = 1'b0;
            end
        end else if (tick) begin
            tx_ph_d = tx_ph_q + 4'd1;
            if (tx_ph_q == 4'd15) begin
                case (tx_st_q)
                    ST_START:  tx_st_d = ST_DATA;
                    ST_DATA: begin
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_bit_d = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'(DATA_BITS-1))
                            tx_st_d = ctrl_q[C_PAR_EN] ? ST_PARITY : ST_STOP;
                    end
                    ST_PARITY: tx_st_d = ST_STOP;
                    ST_STOP: begin
                        tx_stop_d = 1'b1;
                        if (!ctrl_q[C_STOP2] || tx_stop_q) tx_st_d = ST_IDLE;
                    end
                    default:   tx_st_d = ST_IDLE;
                endcase
            end
        end
        case (tx_st_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = tx_sh_d[0];
            ST_PARITY: txd_d = tx_par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    // RX FSM: bits sampled at phase 7, bit boundaries at phase 15
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_ph_d  = rx_ph_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        set_par  = 1'b0;
        set_frm  = 1'b0;
        if (!ctrl_q[C_BAUD_EN] || !ctrl_q[C_RX_EN]) begin
            rx_st_d = ST_IDLE;
            rx_ph_d = '0;
        end else if (rx_st_q == ST_IDLE) begin
            if (rxd_prev && !rxd_s) begin
                rx_st_d  = ST_START;
                rx_ph_d  = '0;
                rx_bit_d = '0;
            end
        end else if (tick) begin
            rx_ph_d = rx_ph_q + 4'd1;
            if (rx_ph_q == 4'd7) begin
                case (rx_st_q)
                    ST_START:  if (rxd_s) rx_st_d = ST_IDLE;
                    ST_DATA:   rx_sh_d = {rxd_s, rx_sh_q[DATA_BITS-1:1]};
                    ST_PARITY: set_par = (rxd_s != par_bit(8'(rx_sh_q), ctrl_q[C_PAR_EVEN]));
                    ST_STOP: begin
                        rx_st_d = ST_IDLE;
                        set_frm = ~rxd_s;
                        rx_push = rxd_s;
                    end
                    default: ;
                endcase
            end else if (rx_ph_q == 4'd15) begin
                case (rx_st_q)
                    ST_START:  rx_st_d = ST_DATA;
                    ST_DATA: begin
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'(DATA_BITS-1))
                            rx_st_d = ctrl_q[C_PAR_EN] ? ST_PARITY : ST_STOP;
                    end
                    ST_PARITY: rx_st_d = ST_STOP;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            ctrl_q      <= '0;
            div_q       <= DIV_RST;
            ie_q        <= '0;
            tx_wm_q     <= '0;
            rx_wm_q     <= '0;
            sticky_q    <= '0;
            irq_q       <= 1'b0;
            txd_q       <= 1'b1;
            tick_cnt_q  <= '0;
            rx_sync_q   <= 3'b111;
            tx_st_q     <= ST_IDLE;
            tx_ph_q     <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            tx_par_q    <= 1'b0;
            tx_stop_q   <= 1'b0;
            rx_st_q     <= ST_IDLE;
            rx_ph_q     <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ctrl_q      <= ctrl_d;
            div_q       <= div_d;
            ie_q        <= ie_d;
            tx_wm_q     <= tx_wm_d;
            rx_wm_q     <= rx_wm_d;
            sticky_q    <= sticky_d;
            irq_q       <= irq_d;
            txd_q       <= txd_d;
            tick_cnt_q  <= tick_cnt_d;
            rx_sync_q   <= rx_sync_d;
            tx_st_q     <= tx_st_d;
            tx_ph_q     <= tx_ph_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            tx_par_q    <= tx_par_d;
            tx_stop_q   <= tx_stop_d;
            rx_st_q     <= rx_st_d;
            rx_ph_q     <= rx_ph_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
        end
    end
endmodule

// File: tb/tb_icb_uart_fifo.sv
// Scoreboard bench for icb_uart_fifo: received bytes are queued as frames are
// driven and checked as RXDATA reads return them.
module tb_icb_uart_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_read = 1'b0, rsp_ready = 1'b1;
    logic        cmd_ready, rsp_valid, irq, txd, rxd;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, rsp_rdata;
    logic        rxd_drv = 1'b1, loop_en = 1'b0;
    logic [31:0] sb[$];
    int          n_chk = 0, n_fail = 0;

    assign rxd = loop_en ? txd : rxd_drv;
    always #5 clk = ~clk;

    icb_uart_fifo dut (
        .clk(clk), .rst_n(rst_n),
        .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready), .i_icb_cmd_addr(cmd_addr),
        .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(cmd_wdata),
        .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_rdata(rsp_rdata),
        .io_irq(irq), .io_txd(txd), .io_rxd(rxd));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic icb(input logic rd_n_wr, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rdat);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_read = rd_n_wr; cmd_addr = a; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        rdat = rsp_rdata;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        icb(1'b0, a, wd, dummy);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] rdat);
        icb(1'b1, a, 32'h0, rdat);
    endtask

    task automatic rd_rx(input string tag);
        logic [31:0] r, e;
        rd(32'h04, r);
        e = (sb.size() != 0) ? sb.pop_front() : 32'h8000_0000;
        chk(tag, r, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // par_mode: 0 none, 1 correct even parity, 2 wrong even parity.
    // rd_at >= 0 issues an RXDATA read accepted at the posedge after negedge rd_at.
    task automatic send_frame(input logic [7:0] d, input int par_mode, input logic stop,
                              input int rd_at);
        logic [11:0] fb;
        int          nb;
        logic [31:0] e;
        fb = '0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = d[i];
        nb = 9;
        if (par_mode != 0) begin
            fb[9] = (par_mode == 1) ? ^d : ~^d;
            nb = 10;
        end
        fb[nb] = stop;
        nb = nb + 1;
        for (int n = 0; n < nb * 16; n++) begin
            @(negedge clk);
            rxd_drv = fb[n / 16];
            if (n == rd_at) begin
                cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h04;
            end else if (rd_at >= 0 && n == rd_at + 1) begin
                cmd_valid = 1'b0;
                chk("push_pop_rsp", {31'b0, rsp_valid}, 32'd1);
                e = (sb.size() != 0) ? sb.pop_front() : 32'h8000_0000;
                chk("push_pop_data", rsp_rdata, e);
            end
        end
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  b55;
        int          n, lo;

        // reset state
        do_reset();
        chk("rst_txd", {31'b0, txd}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_rspv", {31'b0, rsp_valid}, 32'd0);
        rd(32'h10, r); chk("rst_status", r, 32'h0000_0005);
        rd(32'h0C, r); chk("rst_div", r, 32'd53);
        rd(32'h08, r); chk("rst_ctrl", r, 32'd0);
        rd(32'h14, r); chk("rst_ie", r, 32'd0);
        rd(32'h00, r); chk("txdata_rd", r, 32'd0);
        rd(32'h18, r); chk("unmapped_rd", r, 32'd0);

        // 1: 0x55 on txd at 16 clk per bit
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'h03);
        b55 = 8'h55;
        fork
            wr(32'h00, 32'h55);
            begin
                n = 0;
                while (txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
                chk("tx_start_seen", {31'b0, txd}, 32'd0);
                lo = 0;
                while (txd === 1'b0 && lo < 100) begin lo++; @(negedge clk); end
                chk("tx_start_len", lo, 32'd16);
                for (int i = 0; i < 8; i++) begin
                    repeat (8) @(negedge clk);
                    chk($sformatf("tx_bit%0d", i), {31'b0, txd}, {31'b0, b55[i]});
                    repeat (8) @(negedge clk);
                end
                repeat (8) @(negedge clk);
                chk("tx_stop", {31'b0, txd}, 32'd1);
            end
        join

        // 2: TX FIFO overflow with tx_en=0
        do_reset();
        for (int i = 0; i < 9; i++) wr(32'h00, 32'(i));
        rd(32'h10, r);
        chk("tx_full", {31'b0, r[1]}, 32'd1);
        chk("txovf_set", {31'b0, r[7]}, 32'd1);
        chk("tx_cnt8", {28'b0, r[11:8]}, 32'd8);
        wr(32'h10, 32'h80);
        rd(32'h10, r);
        chk("txovf_w1c", {31'b0, r[7]}, 32'd0);
        chk("tx_cnt_kept", {28'b0, r[11:8]}, 32'd8);

        // 3: loopback with even parity
        do_reset();
        loop_en = 1'b1;
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'h1F);
        wr(32'h00, 32'hA5);
        sb.push_back(32'h0000_00A5);
        repeat (220) @(negedge clk);
        rd_rx("loop_rx");
        rd(32'h10, r);
        chk("loop_parerr", {31'b0, r[5]}, 32'd0);
        chk("loop_rx_empty", {31'b0, r[2]}, 32'd1);
        loop_en = 1'b0;

        // 4: bad parity and bad stop
        do_reset();
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'h1D);
        send_frame(8'h3C, 2, 1'b0, -1);
        rd(32'h10, r);
        chk("err_parerr", {31'b0, r[5]}, 32'd1);
        chk("err_frmerr", {31'b0, r[6]}, 32'd1);
        chk("err_no_push", {28'b0, r[19:16]}, 32'd0);
        chk("irq_masked", {31'b0, irq}, 32'd0);
        wr(32'h14, 32'h4);
        repeat (2) @(negedge clk);
        chk("irq_err", {31'b0, irq}, 32'd1);

        // 5: RX overflow, then push+pop on a full FIFO
        do_reset();
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'h05);
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(8'h30 + i), 0, 1'b1, -1);
            if (i < 8) sb.push_back(32'(8'h30 + i));
        end
        rd(32'h10, r);
        chk("rxovf_set", {31'b0, r[4]}, 32'd1);
        chk("rx_full", {31'b0, r[3]}, 32'd1);
        chk("rx_cnt8", {28'b0, r[19:16]}, 32'd8);
        wr(32'h10, 32'h10);
        send_frame(8'hEE, 0, 1'b1, 154);
        sb.push_back(32'h0000_00EE);
        rd(32'h10, r);
        chk("pp_rx_cnt", {28'b0, r[19:16]}, 32'd8);
        chk("pp_no_ovf", {31'b0, r[4]}, 32'd0);
        for (int i = 0; i < 8; i++) rd_rx($sformatf("drain%0d", i));

        // 6: RX watermark irq, empty read, reset mid-frame
        do_reset();
        wr(32'h0C, 32'd0);
        wr(32'h08, 32'h05);
        wr(32'h14, 32'h0002_0002);
        send_frame(8'h11, 0, 1'b1, -1);
        sb.push_back(32'h11);
        chk("wm_irq_1", {31'b0, irq}, 32'd0);
        send_frame(8'h22, 0, 1'b1, -1);
        sb.push_back(32'h22);
        chk("wm_irq_2", {31'b0, irq}, 32'd1);
        rd_rx("wm_rx0");
        rd_rx("wm_rx1");
        rd(32'h04, r);
        chk("rx_empty_rd", r, 32'h8000_0000);
        wr(32'h08, 32'h07);
        wr(32'h14, 32'h0000_0004);
        wr(32'h00, 32'h0F);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_txd", {31'b0, txd}, 32'd1);
        chk("midrst_irq", {31'b0, irq}, 32'd0);
        chk("midrst_rspv", {31'b0, rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(32'h08, r); chk("midrst_ctrl", r, 32'd0);
        rd(32'h0C, r); chk("midrst_div", r, 32'd53);
        rd(32'h14, r); chk("midrst_ie", r, 32'd0);
        rd(32'h10, r); chk("midrst_status", r, 32'h0000_0005);
        repeat (20) @(negedge clk);
        chk("midrst_txd_idle", {31'b0, txd}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
